// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer: five-phase instruction sequencer with level-sensitive
// interrupt injection (CALL_ISR) and RETI handling.
// Revision: 1.0
// ============================================================================

`ifndef CONTROL_SEQUENCER_DEFS
`define CONTROL_SEQUENCER_DEFS
`define STATE_COUNT    3
`define STATE_IF       3'd0
`define STATE_ID       3'd1
`define STATE_EX       3'd2
`define STATE_MEM      3'd3
`define STATE_WB       3'd4
`define OPCODE_COUNT   8
`define GROUP_COUNT    4
`define TYPE_ALU       0
`define TYPE_RET       1
`define TYPE_RETI      2
`define TYPE_RCALL     3
`define TYPE_CALL_ISR  4
`define TYPE_LOAD      5
`define TYPE_STORE     6
`define TYPE_NOP       7
`endif

module control_sequencer #(
    parameter int IRQ_COUNT = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic [`OPCODE_COUNT-1:0]  opcode_type,
    input  logic [`GROUP_COUNT-1:0]   opcode_group,
    input  logic                      sreg_i,
    input  logic [IRQ_COUNT-1:0]      irq,
    output logic [`STATE_COUNT-1:0]   state,
    output logic                      cycle_count,
    output logic                      isr_active,
    output logic [7:0]                isr_vector,
    output logic [IRQ_COUNT-1:0]      irq_ack,
    output logic                      clear_i,
    output logic                      set_i
);

    typedef enum logic [`STATE_COUNT-1:0] {
        S_IF  = `STATE_IF,
        S_ID  = `STATE_ID,
        S_EX  = `STATE_EX,
        S_MEM = `STATE_MEM,
        S_WB  = `STATE_WB
    } phase_t;

    phase_t     phase;
    logic [2:0] isr_idx;
    logic [2:0] win_idx;
    logic       long_mem;
    logic       is_reti;
    logic       take_irq;
    logic       legal;
    logic       isr_entry;
    logic       unused_inputs;

    assign state = phase;

    // Lowest index wins: scan from the top so lower indices overwrite.
    always_comb begin
        win_idx = 3'd0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (irq[i]) win_idx = 3'(i);
        end
    end

    assign is_reti  = opcode_type[`TYPE_RETI];
    assign long_mem = opcode_type[`TYPE_RET] | opcode_type[`TYPE_RETI] |
                      opcode_type[`TYPE_RCALL] | opcode_type[`TYPE_CALL_ISR] |
                      isr_active;
    assign take_irq = sreg_i & (|irq) & ~is_reti & ~isr_active;
    assign legal    = (phase == S_IF) || (phase == S_ID) || (phase == S_EX) ||
                      (phase == S_MEM) || (phase == S_WB);

    assign unused_inputs = ^{opcode_group, opcode_type[`TYPE_ALU],
                             opcode_type[`TYPE_NOP:`TYPE_LOAD]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= S_IF;
            cycle_count <= 1'b0;
            isr_active  <= 1'b0;
            isr_vector  <= 8'd0;
            isr_idx     <= 3'd0;
        end else if (!legal) begin
            phase       <= S_IF;
            cycle_count <= 1'b0;
        end else if (!stall) begin
            case (phase)
                S_IF:  phase <= S_ID;
                S_ID:  phase <= S_EX;
                S_EX:  phase <= S_MEM;
                S_MEM: begin
                    if (long_mem && !cycle_count) begin
                        cycle_count <= 1'b1;
                    end else begin
                        cycle_count <= 1'b0;
                        phase       <= S_WB;
                    end
                end
                S_WB: begin
                    // A finishing CALL_ISR always drops isr_active here.
                    phase      <= S_IF;
                    isr_active <= take_irq;
                    if (take_irq) begin
                        isr_idx    <= win_idx;
                        isr_vector <= {3'b000, {1'b0, win_idx} + 4'd1, 1'b0};
                    end
                end
                default: begin
                    phase       <= S_IF;
                    cycle_count <= 1'b0;
                end
            endcase
        end
    end

    // Pulses depend on the live stall so a stalled cycle never emits them.
    assign isr_entry = (phase == S_IF) && isr_active && !stall;
    assign clear_i   = isr_entry;
    assign set_i     = (phase == S_WB) && !stall && is_reti && !isr_active;

    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            irq_ack[i] = isr_entry && (isr_idx == 3'(i));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_control_sequencer: randomized scoreboard bench for control_sequencer.
// Revision: 1.0
// ============================================================================

`ifndef CONTROL_SEQUENCER_DEFS
`define CONTROL_SEQUENCER_DEFS
`define STATE_COUNT    3
`define STATE_IF       3'd0
`define STATE_ID       3'd1
`define STATE_EX       3'd2
`define STATE_MEM      3'd3
`define STATE_WB       3'd4
`define OPCODE_COUNT   8
`define GROUP_COUNT    4
`define TYPE_ALU       0
`define TYPE_RET       1
`define TYPE_RETI      2
`define TYPE_RCALL     3
`define TYPE_CALL_ISR  4
`define TYPE_LOAD      5
`define TYPE_STORE     6
`define TYPE_NOP       7
`endif

module tb_control_sequencer;

    localparam int N      = 4;
    localparam int CYCLES = 4000;

    logic                     clk;
    logic                     reset_n;
    logic                     stall;
    logic [`OPCODE_COUNT-1:0] opcode_type;
    logic [`GROUP_COUNT-1:0]  opcode_group;
    logic                     sreg_i;
    logic [N-1:0]             irq;
    logic [`STATE_COUNT-1:0]  state;
    logic                     cycle_count;
    logic                     isr_active;
    logic [7:0]               isr_vector;
    logic [N-1:0]             irq_ack;
    logic                     clear_i;
    logic                     set_i;

    control_sequencer #(.IRQ_COUNT(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .opcode_type  (opcode_type),
        .opcode_group (opcode_group),
        .sreg_i       (sreg_i),
        .irq          (irq),
        .state        (state),
        .cycle_count  (cycle_count),
        .isr_active   (isr_active),
        .isr_vector   (isr_vector),
        .irq_ack      (irq_ack),
        .clear_i      (clear_i),
        .set_i        (set_i)
    );

    typedef struct {
        int st;
        int cc;
        int act;
        int vec;
        int chkvec;
        int ack;
        int clr;
        int set;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   done    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            if (q.size() == 0) begin
                check("queue_depth", q.size(), 1);
            end else begin
                e = q.pop_front();
                check("state",       int'(state),       e.st);
                check("cycle_count", int'(cycle_count), e.cc);
                check("isr_active",  int'(isr_active),  e.act);
                if (e.chkvec != 0) check("isr_vector", int'(isr_vector), e.vec);
                check("irq_ack",     int'(irq_ack),     e.ack);
                check("clear_i",     int'(clear_i),     e.clr);
                check("set_i",       int'(set_i),       e.set);
            end
        end
    end

    // Driver plus instruction-level reference model.
    initial begin
        int   m_ph, m_sub, m_act, m_idx;
        int   cur_op;
        bit   rst, long_op, take, did_isr_reset;
        int   ops[7];
        exp_t e;

        ops = '{`TYPE_ALU, `TYPE_RET, `TYPE_RETI, `TYPE_RCALL,
                `TYPE_LOAD, `TYPE_STORE, `TYPE_NOP};
        m_ph = 0; m_sub = 0; m_act = 0; m_idx = 0;
        cur_op = `TYPE_ALU;
        did_isr_reset = 1'b0;
        reset_n = 1'b0; stall = 1'b0; sreg_i = 1'b0; irq = '0;
        opcode_type = '0; opcode_group = '0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc < 3) || ($urandom_range(0, 299) == 0);
            if (m_act != 0 && m_ph == 3 && m_sub == 1 && !did_isr_reset) begin
                rst = 1'b1;
                did_isr_reset = 1'b1;
            end
            stall  = ($urandom_range(0, 3) == 0);
            sreg_i = ($urandom_range(0, 9) < 7);
            irq    = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
            if (m_ph == 0) cur_op = (m_act != 0) ? `TYPE_CALL_ISR : ops[$urandom_range(0, 6)];
            opcode_type  = `OPCODE_COUNT'(1 << cur_op);
            opcode_group = `GROUP_COUNT'($urandom);
            reset_n      = !rst;

            if (rst) begin
                e = '{st: 0, cc: 0, act: 0, vec: 0, chkvec: 1, ack: 0, clr: 0, set: 0};
            end else begin
                e.st     = m_ph;
                e.cc     = m_sub;
                e.act    = m_act;
                e.vec    = 2 * (m_idx + 1);
                e.chkvec = m_act;
                e.ack    = (!stall && m_ph == 0 && m_act != 0) ? (1 << m_idx) : 0;
                e.clr    = (!stall && m_ph == 0 && m_act != 0) ? 1 : 0;
                e.set    = (!stall && m_ph == 4 && cur_op == `TYPE_RETI && m_act == 0) ? 1 : 0;
            end
            q.push_back(e);

            if (rst) begin
                m_ph = 0; m_sub = 0; m_act = 0; m_idx = 0;
            end else if (!stall) begin
                case (m_ph)
                    0, 1, 2: m_ph = m_ph + 1;
                    3: begin
                        long_op = (cur_op == `TYPE_RET) || (cur_op == `TYPE_RETI) ||
                                  (cur_op == `TYPE_RCALL) || (cur_op == `TYPE_CALL_ISR);
                        if (long_op && m_sub == 0) m_sub = 1;
                        else begin m_sub = 0; m_ph = 4; end
                    end
                    default: begin
                        take = sreg_i && (irq != 0) && (cur_op != `TYPE_RETI) && (m_act == 0);
                        if (take) begin
                            m_idx = 0;
                            while (irq[m_idx] == 1'b0) m_idx++;
                        end
                        m_act = take ? 1 : 0;
                        m_ph  = 0;
                    end
                endcase
            end
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        check("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter IRQ_COUNT, default 4, number of interrupt request lines (1..8).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold current state and cycle_count this cycle (memory/IO wait).
REQ-005 opcode_type  input  `OPCODE_COUNT  decoded instruction type, valid from ID through WB.
REQ-006 opcode_group  input  `GROUP_COUNT  decoded group flags, valid from ID through WB.
REQ-007 sreg_i  input  1  global interrupt enable (SREG I flag).
REQ-008 irq  input  IRQ_COUNT  level-sensitive interrupt requests.
REQ-009 state  output  `STATE_COUNT  current phase: `STATE_IF, `STATE_ID, `STATE_EX, `STATE_MEM, `STATE_WB.
REQ-010 cycle_count  output  1  sub-cycle index within a two-cycle MEM phase; 0 otherwise.
REQ-011 isr_active  output  1  current instruction is an injected CALL_ISR; decoder forces `TYPE_CALL_ISR while high.
REQ-012 isr_vector  output  8  vector address of the serviced interrupt, 2*(index+1).
REQ-013 irq_ack  output  IRQ_COUNT  one-hot, one-cycle acknowledge of the serviced line.
REQ-014 clear_i  output  1  one-cycle pulse: clear SREG I on ISR entry.
REQ-015 set_i  output  1  one-cycle pulse: set SREG I on RETI completion.

Function
REQ-016 Phase sequence SHALL be IF -> ID -> EX -> MEM -> WB -> IF; every instruction, including CALL_ISR, visits all five phases.
REQ-017 While stall=1, state, cycle_count, isr_active and isr_vector SHALL hold; irq_ack, clear_i and set_i SHALL be 0.
REQ-018 Each phase SHALL last one unstalled cycle, except MEM for `TYPE_RET, `TYPE_RETI, `TYPE_RCALL and `TYPE_CALL_ISR, which SHALL last two unstalled cycles with cycle_count 0 then 1.
REQ-019 cycle_count SHALL return to 0 on leaving MEM and SHALL be 0 in every other phase.
REQ-020 Interrupt decision SHALL be made on the last unstalled WB cycle: taken iff sreg_i=1, |irq=1, current instruction not `TYPE_RETI, and isr_active=0.
REQ-021 Arbitration SHALL be fixed priority, lowest irq index wins.
REQ-022 On a taken decision, next cycle SHALL enter IF with isr_active=1 and isr_vector latched from the winner; both SHALL hold unchanged until the injected instruction's WB completes.
REQ-023 irq_ack SHALL pulse the winner's bit during the first unstalled IF cycle of the injected instruction; all other bits 0.
REQ-024 clear_i SHALL pulse during the first unstalled IF cycle of the injected instruction.
REQ-025 isr_active SHALL fall to 0 on the transition from the injected instruction's WB to the next IF.
REQ-026 set_i SHALL pulse during the last unstalled WB cycle of `TYPE_RETI; no interrupt taken at that boundary, so at least one instruction executes after RETI.
REQ-027 irq deasserting after the decision SHALL NOT cancel the injected CALL_ISR; the latched vector is used.
REQ-028 A state value outside the five legal encodings SHALL transition to IF with cycle_count 0 on the next clock.
REQ-029 Back-to-back interrupts: a pending irq SHALL be evaluated at the WB of every normal instruction, never at the WB of the injected CALL_ISR.

Reset
REQ-030 While reset_n=0: state=`STATE_IF, cycle_count=0, isr_active=0, isr_vector=0, irq_ack=0, clear_i=0, set_i=0, asynchronously.
REQ-031 Reset asserted mid-instruction or mid-ISR SHALL abort it; after release, sequencing restarts at IF with no pending interrupt state retained.

Verification
REQ-032 Release reset, ALU opcode, no stall -> state IF,ID,EX,MEM,WB repeating, cycle_count always 0.
REQ-033 `TYPE_RET with stall=1 for 3 cycles in MEM cycle 0 -> MEM occupies 5 cycles, cycle_count 0,0,0,0,1, then WB.
REQ-034 sreg_i=1, irq=4'b0110 at WB of ADD -> next IF isr_active=1, isr_vector=4, irq_ack=4'b0010 and clear_i for one cycle; isr_active low after WB.
REQ-035 sreg_i=1, irq=4'b0001 held during RETI WB -> set_i pulse, no injection; next instruction completes, then injection with isr_vector=2.
REQ-036 sreg_i=0, irq=4'b1111 -> no injection, irq_ack stays 0.
REQ-037 reset_n low during injected CALL_ISR MEM cycle 1 -> all outputs reset immediately; after release, IF with isr_active=0.
